// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and constants for the rr_grant_ctrl round-robin arbiter.
package rr_grant_ctrl_pkg;

    localparam int REQ_NUM      = 4;
    localparam int IDX_BIT      = 2;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic               vld;
        logic [IDX_BIT-1:0] idx;
    } pick_t;

endpackage

// File: rtl/rr_grant_ctrl_onehot_dec.sv
// Combinational index to one-hot decoder; an index with no matching output bit decodes to zero.
module onehot_dec
    import rr_grant_ctrl_pkg::*;
#(
    parameter int P_IDX_BIT = IDX_BIT,
    parameter int P_OUT_NUM = REQ_NUM
) (
    input  logic [P_IDX_BIT-1:0] idx,
    output logic [P_OUT_NUM-1:0] onehot
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        onehot = '0;
        for (int i = 0; i < P_OUT_NUM; i++) begin
            if (idx == P_IDX_BIT'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Four-way round-robin arbiter with registered one-hot grant and break-before-make gap.
// Optional forced release after P_MAX_HOLD cycles is compiled in with `define RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl
    import rr_grant_ctrl_pkg::*;
#(
    parameter int P_REQ_NUM  = REQ_NUM,
    parameter int P_IDX_BIT  = IDX_BIT,
    parameter int P_MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [P_REQ_NUM-1:0] req_i,
    output logic [P_REQ_NUM-1:0] gnt_o,
    output logic [P_IDX_BIT-1:0] gnt_idx_o,
    output logic                 gnt_vld_o,
    output logic                 timeout_o
);

    if (P_MAX_HOLD < 1 || P_MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_grant_ctrl: P_MAX_HOLD must be within 1..255");
    end

    state_t               state_q, state_d;
    logic [P_IDX_BIT-1:0] ptr_q;
    logic [P_REQ_NUM-1:0] req_elig;
    logic [P_REQ_NUM-1:0] dec_out;
    logic [P_REQ_NUM-1:0] gnt_d;
    logic                 req_held;
    logic                 force_rel;
    pick_t                pick;

    // Scan upward from ptr with wrap; iterating from the far end lets the nearest hit win.
    function automatic pick_t rr_pick(input logic [P_REQ_NUM-1:0] req,
                                      input logic [P_IDX_BIT-1:0] start);
        pick_t                res;
        logic [P_IDX_BIT-1:0] idx;
        res = '0;
        for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
            idx = start + P_IDX_BIT'(i);
            if (req[idx]) begin
                res.vld = 1'b1;
                res.idx = idx;
            end
        end
        return res;
    endfunction

    assign pick     = rr_pick(req_elig, ptr_q);
    assign req_held = req_i[gnt_idx_o];

    onehot_dec #(
        .P_IDX_BIT (P_IDX_BIT),
        .P_OUT_NUM (P_REQ_NUM)
    ) u_dec (
        .idx    (gnt_idx_o),
        .onehot (dec_out)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick.vld) state_d = GRANT;
            GRANT:   if (!req_held || force_rel) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = dec_out & {P_REQ_NUM{state_q == GRANT}};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q     <= '0;
            gnt_idx_o <= '0;
            gnt_o     <= '0;
            gnt_vld_o <= 1'b0;
        end else begin
            gnt_o     <= gnt_d;
            gnt_vld_o <= |gnt_d;
            if (state_q == IDLE && pick.vld) gnt_idx_o <= pick.idx;
            if (state_q == GRANT && state_d == GAP) ptr_q <= gnt_idx_o + 1'b1;
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    logic [7:0]           hold_cnt_q;
    logic [P_REQ_NUM-1:0] mask_q;
    logic                 tmo_q;

    // A voluntary release in the same cycle as the limit is not a timeout.
    assign force_rel = (state_q == GRANT) && req_held &&
                       (hold_cnt_q + 8'd1 == 8'(P_MAX_HOLD));
    assign req_elig  = req_i & ~mask_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hold_cnt_q <= '0;
            mask_q     <= '0;
            tmo_q      <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            hold_cnt_q <= (state_q == GRANT) ? hold_cnt_q + 8'd1 : 8'd0;
            // A mask bit clears once its request is seen low.
            mask_q     <= (mask_q & req_i) | (force_rel ? dec_out : '0);
            // Extra stage aligns the pulse with the first cycle the grant reads zero.
            tmo_q      <= force_rel;
            timeout_o  <= tmo_q;
        end
    end
`else
    assign force_rel = 1'b0;
    assign req_elig  = req_i;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: stimulus queues expected grants, a monitor checks each new grant.
module tb_rr_grant_ctrl;

    logic       clk_i;
    logic       rst_n_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_vld_o;
    logic       timeout_o;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fails = 0;

    rr_grant_ctrl #(
        .P_MAX_HOLD (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .gnt_vld_o (gnt_vld_o),
        .timeout_o (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input int idx);
        exp_t e;
        e.idx = 2'(idx);
        e.gnt = 4'b0001 << idx;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input string name, output int waited);
        waited = 0;
        while (!gnt_vld_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        check({name, "_seen"}, 32'(gnt_vld_o), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (gnt_vld_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_released"}, 32'(gnt_vld_o), 32'd0);
    endtask

    // Monitor: every rising grant pops one expectation.
    initial begin
        logic prev_vld;
        exp_t e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk_i);
            if (gnt_vld_o && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fails++;
                    $display("FAIL unexpected_grant: got gnt %b, no grant expected", gnt_o);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_vec", 32'(gnt_o), 32'(e.gnt));
                    check("grant_idx", 32'(gnt_idx_o), 32'(e.idx));
                end
            end
            prev_vld = gnt_vld_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int g;
        rst_n_i = 1'b0;
        req_i   = 4'b1111;

        // Reset held with all requests high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("reset_gnt", 32'(gnt_o), 32'd0);
        end
        check("reset_vld", 32'(gnt_vld_o), 32'd0);
        check("reset_idx", 32'(gnt_idx_o), 32'd0);
        check("reset_tmo", 32'(timeout_o), 32'd0);

        expect_grant(0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("first_edge_no_grant", 32'(gnt_o), 32'd0);
        wait_grant("first", waited);
        check("grant_latency", 32'(waited), 32'd1);

        // Rotation: drop the granted bit one cycle after each grant, raise it again once released.
        for (int k = 0; k < 4; k++) begin
            g = k;
            expect_grant((k + 1) % 4);
            @(negedge clk_i);
            req_i[g] = 1'b0;
            wait_idle("rot");
            req_i[g] = 1'b1;
            wait_grant("rot", waited);
            check("break_before_make", 32'(waited >= 1), 32'd1);
        end

        // Pointer skip: release requester 1 so ptr = 2, then 0011 must wrap to requester 0.
        expect_grant(1);
        req_i = 4'b0010;
        wait_idle("skip_pre");
        wait_grant("skip_pre", waited);
        req_i = 4'b0000;
        wait_idle("skip_rel");
        @(negedge clk_i);
        expect_grant(0);
        req_i = 4'b0011;
        wait_grant("skip", waited);
        req_i = 4'b0000;
        wait_idle("skip");

        // Reset mid-grant on requester 2.
        expect_grant(2);
        req_i = 4'b0100;
        wait_grant("mid", waited);
        req_i = 4'b0101;
        @(negedge clk_i);
        check("other_req_ignored", 32'(gnt_o), 32'b0100);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check("midrst_gnt", 32'(gnt_o), 32'd0);
        check("midrst_vld", 32'(gnt_vld_o), 32'd0);
        check("midrst_idx", 32'(gnt_idx_o), 32'd0);
        expect_grant(0);
        rst_n_i = 1'b1;
        wait_grant("after_rst", waited);
        req_i = 4'b0000;
        wait_idle("after_rst");

`ifdef RR_GRANT_TIMEOUT_EN
        begin
            int width = 0;
            int pulses = 0;
            expect_grant(0);
            req_i = 4'b0001;
            wait_grant("tmo", waited);
            for (int i = 0; i < 14; i++) begin
                if (gnt_vld_o) width++;
                if (timeout_o) pulses++;
                @(negedge clk_i);
            end
            check("tmo_width", 32'(width), 32'd4);
            check("tmo_pulses", 32'(pulses), 32'd1);

            expect_grant(1);
            req_i = 4'b0011;
            wait_grant("tmo_next", waited);
            req_i = 4'b0001;
            wait_idle("tmo_next");
            repeat (10) @(negedge clk_i);
            check("masked_no_regrant", 32'(gnt_vld_o), 32'd0);

            req_i = 4'b0000;
            @(negedge clk_i);
            expect_grant(0);
            req_i = 4'b0001;
            wait_grant("unmasked", waited);
            req_i = 4'b0000;
            wait_idle("unmasked");
        end
`else
        begin
            int bad_g = 0;
            int bad_t = 0;
            expect_grant(0);
            req_i = 4'b0001;
            wait_grant("hold", waited);
            for (int i = 0; i < 300; i++) begin
                if (gnt_o !== 4'b0001) bad_g++;
                if (timeout_o !== 1'b0) bad_t++;
                @(negedge clk_i);
            end
            check("hold_gnt_cycles_off", 32'(bad_g), 32'd0);
            check("hold_tmo_cycles_on", 32'(bad_t), 32'd0);
            req_i = 4'b0000;
            wait_idle("hold");
        end
`endif

        repeat (4) @(negedge clk_i);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
